// File: rtl/mem_stage_dmem_ctrl.sv
// rtl/mem_stage_dmem_ctrl.sv - EX/MEM consumer: dmem handshake, lane alignment, load extract, writeback
// Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN
module mem_stage_dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic        timeout_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;

  logic [1:0]  off;
  logic        is_half, is_word;
  logic        mem_op, mis, access, done;
  logic [31:0] ld_shift, ld_data;

  assign off     = alu_addr[1:0];
  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = (funct3[1:0] == 2'b10);
  assign mem_op  = valid_in & (mem_read | mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis        = mem_op & ((is_half & off[0]) | (is_word & (off != 2'b00)));
  assign misaligned = mis;
`else
  assign mis = 1'b0;
`endif

  // A trapped access never reaches the memory and never stalls.
  assign access       = mem_op & ~mis;
  assign done         = access & dmem_resp;
  assign stall        = access & ~dmem_resp;
  assign dmem_read    = access & mem_read;
  assign dmem_write   = access & mem_write & ~mem_read;
  assign dmem_address = {alu_addr[31:2], 2'b00};

  always_comb begin
    dmem_mbe   = 4'b0000;
    dmem_wdata = store_data << {off, 3'b000};
    if (is_word) begin
      dmem_wdata = store_data;
    end
    if (dmem_write) begin
      case (funct3[1:0])
        2'b00:   dmem_mbe = 4'b0001 << off;
        2'b01:   dmem_mbe = 4'b0011 << off;
        default: dmem_mbe = 4'b1111;
      endcase
    end
  end

  assign ld_shift = dmem_rdata >> {off, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (funct3)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (stall) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (dmem_resp) begin
          state_d = ST_IDLE;
        end
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // The access keeps waiting; the flag only records that it took too long.
        if (cnt_d == TIMEOUT_VAL) begin
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (mis) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = 5'd0;
      wb_data_d  = alu_addr;
    end else if (done) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = dmem_read ? rd_in : 5'd0;
      wb_data_d  = dmem_read ? ld_data : 32'h0;
    end else if (valid_in & ~mem_read & ~mem_write) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = rd_in;
      wb_data_d  = alu_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// tb/tb_mem_stage_dmem_ctrl.sv - directed and randomized checks of mem_stage_dmem_ctrl
module tb_mem_stage_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_addr, store_data;
  logic [4:0]  rd_in;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        timeout_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  always #5 clk = ~clk;

  mem_stage_dmem_ctrl dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_addr(alu_addr),
    .store_data(store_data), .rd_in(rd_in), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef MEM_MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_mbe(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m = 4'b0000;
    int o = int'(a[1:0]);
    for (int i = 0; i < nbytes(f3); i++)
      if (o + i < 4) m[o + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    longint v = longint'(rdata >> (8 * int'(a[1:0])));
    int n = nbytes(f3);
    if (n < 4) begin
      v = v % (longint'(1) << (8 * n));
      if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    end
    return v[31:0];
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (nbytes(f3) == 2 && a[0]) || (nbytes(f3) == 4 && a[1:0] != 2'b00);
`else
    return (f3 == 3'b111) && (a == 32'h1) && 1'b0;
`endif
  endfunction

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdata, input logic [4:0] rdi, input int dly);
    bit mem = rd | wr;
    bit mis = mem && ref_mis(f3, a);
    bit acc = mem && !mis;
    bit wr_eff = acc && wr && !rd;
    valid_in = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; alu_addr = a;
    store_data = sd; rd_in = rdi; dmem_rdata = rdata; dmem_resp = acc && (dly == 0);
    #2;
    chk("dmem_read", dmem_read, acc && rd);
    chk("dmem_write", dmem_write, wr_eff);
    chk("dmem_address", dmem_address, a & ~32'h3);
    chk("dmem_mbe", dmem_mbe, wr_eff ? ref_mbe(f3, a) : 4'b0000);
    if (wr_eff) chk("dmem_wdata", dmem_wdata, nbytes(f3) == 4 ? sd : sd << (8 * int'(a[1:0])));
    chk("stall", stall, acc && dly != 0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misaligned", misaligned, mis);
`endif
    if (acc) begin
      for (int c = 1; c <= dly; c++) begin
        @(posedge clk); #1;
        chk("wb_valid_wait", wb_valid, 0);
        chk("dmem_read_hold", dmem_read, rd);
        if (c == dly) dmem_resp = 1'b1;
        #1;
        chk("stall_wait", stall, c != dly);
      end
    end
    @(posedge clk); #1;
    if (mis) begin
      exp_rd = 5'd0; exp_data = a;
    end else if (acc) begin
      exp_rd = rd ? rdi : 5'd0;
      exp_data = rd ? ref_load(f3, a, rdata) : 32'h0;
    end else begin
      exp_rd = rdi; exp_data = a;
    end
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_resp = 1'b0;
    chk("wb_valid", wb_valid, 1);
    chk("wb_rd", wb_rd, exp_rd);
    chk("wb_data", wb_data, exp_data);
  endtask

  task automatic bubble();
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_resp = 1'b0;
    @(posedge clk); #1;
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_wb_rd", wb_rd, exp_rd);
    chk("idle_wb_data", wb_data, exp_data);
  endtask

  initial begin
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst = 1'b0; valid_in = 0; mem_read = 0; mem_write = 0; funct3 = 0;
    alu_addr = 0; store_data = 0; rd_in = 0; dmem_rdata = 0; dmem_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_timeout", timeout_err, 0);
    rst = 1'b1;
    exp_rd = 0; exp_data = 0;

    access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd9, 3);
    access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 5'd3, 0);
    chk("lb_sign", wb_data, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 5'd3, 0);
    chk("lbu_zero", wb_data, 32'h00000080);
    access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 5'd4, 2);
    access(0, 0, 3'b000, 32'h1234, 32'h0, 32'h0, 5'd5, 0);
    chk("nonmem_data", wb_data, 32'h1234);
    bubble();
    access(1, 1, 3'b010, 32'h40, 32'h5555AAAA, 32'h0BADF00D, 5'd6, 1);
    access(1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 5'd8, 1);
    access(0, 1, 3'b001, 32'h203, 32'h0000BEEF, 32'h0, 5'd2, 1);

    for (int i = 0; i < 40; i++) begin
      int kind = int'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      case (kind)
        0: access(1, 0, ld_f3[$urandom_range(0, 4)], a, $urandom, $urandom,
                  5'($urandom), int'($urandom_range(0, 3)));
        1: access(0, 1, 3'($urandom_range(0, 2)), a, $urandom, $urandom,
                  5'($urandom), int'($urandom_range(0, 3)));
        2: access(0, 0, 3'($urandom), a, $urandom, $urandom, 5'($urandom), 0);
        default: bubble();
      endcase
    end

    valid_in = 1; mem_read = 1; mem_write = 0; funct3 = 3'b010; alu_addr = 32'h300;
    rd_in = 5'd7; dmem_rdata = 32'h12345678; dmem_resp = 0;
    repeat (64) @(posedge clk);
    #1;
    chk("timeout_early", timeout_err, 0);
    chk("timeout_stall", stall, 1);
    @(posedge clk); #1;
    chk("timeout_set", timeout_err, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("timeout_sticky", timeout_err, 1);
    dmem_resp = 1; #1;
    chk("timeout_resp_stall", stall, 0);
    @(posedge clk); #1;
    valid_in = 0; mem_read = 0; dmem_resp = 0;
    exp_rd = 5'd7; exp_data = 32'h12345678;
    chk("timeout_wb_valid", wb_valid, 1);
    chk("timeout_wb_data", wb_data, exp_data);
    chk("timeout_wb_rd", wb_rd, exp_rd);
    chk("timeout_kept", timeout_err, 1);

    valid_in = 1; mem_read = 1; alu_addr = 32'h400;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_timeout", timeout_err, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_wb_rd", wb_rd, 0);
    chk("midrst_wb_data", wb_data, 0);
    rst = 1'b1;
    exp_rd = 0; exp_data = 0;
    bubble();
    access(1, 0, 3'b101, 32'h502, 32'h0, 32'h9ABC1234, 5'd11, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
